commit_trace_buffer: RTL and testbench

- Synthesizable trace recorder that captures every architectural commit (PC, destination register, write data, cycle stamp) into a circular buffer.
- Sits beside the ROB commit port of OoO_top.
- Detects end of program in hardware: fetch PC wraps back to 0, then a fixed post-trigger window elapses. A timeout also ends recording.
- Generalises our per-cycle trace logging to COMMIT_W commit lanes, configurable depth, and stop-on-full or overwrite-oldest modes. The buffer is drained through a valid/ready read port.

---
 rtl/commit_trace_buffer.sv | 159 +++++++++++++++
 tb/tb_commit_trace_buffer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// Commit trace recorder: captures retiring instructions into a circular buffer
// and stops itself once the fetch PC wraps to zero (or a timeout expires).
module commit_trace_buffer #(
  parameter int COMMIT_W    = 2,
  parameter int DEPTH       = 64,
  parameter int PC_W        = 9,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 10000,
  parameter int POST_CYCLES = 50
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [COMMIT_W-1:0]        commit_valid,
  input  logic [COMMIT_W*PC_W-1:0]   commit_pc,
  input  logic [COMMIT_W-1:0]        commit_we,
  input  logic [COMMIT_W*5-1:0]      commit_rd,
  input  logic [COMMIT_W*DATA_W-1:0] commit_data,
  input  logic                       fetch_valid,
  input  logic [PC_W-1:0]            fetch_pc,
  input  logic                       mode_wrap,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [PC_W-1:0]            rd_pc,
  output logic                       rd_we,
  output logic [4:0]                 rd_rd,
  output logic [DATA_W-1:0]          rd_data,
  output logic [31:0]                rd_stamp,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                drops,
  output logic [1:0]                 state,
  output logic                       done,
  output logic                       timeout
);

  // state | meaning
  // IDLE  | recording, waiting for the first non-zero fetch PC
  // RUN   | recording, watching for the fetch PC to wrap back to 0
  // POST  | recording the post-trigger window
  // DONE  | recording stopped; buffer can still be drained
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_POST = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = PC_W + 1 + 5 + DATA_W + 32;
  localparam logic [AW-1:0] AMASK = AW'(DEPTH - 1);

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   head, tail, head_nxt, tail_nxt;
  logic [CW-1:0]   count_nxt;
  logic [2:0]      ndrop;
  logic [16:0]     drops_sum;
  logic [31:0]     stamp, tcnt, post_cnt;
  logic [PC_W-1:0] prev_pc;
  logic [1:0]      state_nxt;
  logic            timed_out, pop, recording;

  logic [COMMIT_W-1:0] lane_wr;
  logic [AW-1:0]       lane_addr  [COMMIT_W];
  logic [EW-1:0]       lane_entry [COMMIT_W];

  assign rd_valid  = (count != '0);
  assign done      = (state == S_DONE);
  assign recording = (state != S_DONE);
  assign pop       = rd_valid && rd_ready;
  assign {rd_pc, rd_we, rd_rd, rd_data, rd_stamp} = mem[head & AMASK];

  // Pop frees its slot first; then valid lanes are packed in lane order.
  always_comb begin
    head_nxt  = head + AW'(pop);
    count_nxt = count - CW'(pop);
    tail_nxt  = tail;
    ndrop     = '0;
    lane_wr   = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      lane_addr[i]  = tail_nxt & AMASK;
      lane_entry[i] = {commit_pc[i*PC_W +: PC_W], commit_we[i], commit_rd[i*5 +: 5],
                       commit_data[i*DATA_W +: DATA_W], stamp};
      if (recording && commit_valid[i]) begin
        if (count_nxt != CW'(DEPTH)) begin
          lane_wr[i] = 1'b1;
          tail_nxt   = tail_nxt + AW'(1);
          count_nxt  = count_nxt + CW'(1);
        end else if (mode_wrap) begin
          lane_wr[i] = 1'b1;
          tail_nxt   = tail_nxt + AW'(1);
          head_nxt   = head_nxt + AW'(1);
          ndrop      = ndrop + 3'd1;
        end else begin
          ndrop = ndrop + 3'd1;
        end
      end
    end
  end

  assign drops_sum = {1'b0, drops} + 17'(ndrop);

  // Wrap detection is checked before the timeout so a coincident wrap wins.
  always_comb begin
    state_nxt = state;
    timed_out = 1'b0;
    case (state)
      S_IDLE: begin
        if (fetch_valid && fetch_pc != '0) begin
          state_nxt = S_RUN;
        end else if (tcnt == 32'(TIMEOUT - 1)) begin
          state_nxt = S_DONE;
          timed_out = 1'b1;
        end
      end
      S_RUN: begin
        if (fetch_valid && fetch_pc == '0 && prev_pc != '0) begin
          state_nxt = S_POST;
        end else if (tcnt == 32'(TIMEOUT - 1)) begin
          state_nxt = S_DONE;
          timed_out = 1'b1;
        end
      end
      S_POST: if (post_cnt == '0) state_nxt = S_DONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < COMMIT_W; i++)
      if (rst && lane_wr[i]) mem[lane_addr[i]] <= lane_entry[i];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      drops    <= '0;
      stamp    <= '0;
      tcnt     <= '0;
      post_cnt <= '0;
      timeout  <= 1'b0;
      prev_pc  <= '0;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
      tail  <= tail_nxt;
      count <= count_nxt;
      drops <= drops_sum[16] ? 16'hFFFF : drops_sum[15:0];
      stamp <= stamp + 32'd1;
      if (timed_out) timeout <= 1'b1;
      if (fetch_valid) prev_pc <= fetch_pc;
      if (state_nxt != state) tcnt <= '0;
      else if (state == S_IDLE || state == S_RUN) tcnt <= tcnt + 32'd1;
      if (state == S_RUN && state_nxt == S_POST) post_cnt <= 32'(POST_CYCLES - 1);
      else if (state == S_POST && post_cnt != '0) post_cnt <= post_cnt - 32'd1;
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: two instances (long and short
// timeout) share the same stimulus.
module tb_commit_trace_buffer;
  typedef struct {
    logic [8:0]  pc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] stamp;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  commit_valid;
  logic [17:0] commit_pc;
  logic [1:0]  commit_we;
  logic [9:0]  commit_rd;
  logic [63:0] commit_data;
  logic        fetch_valid;
  logic [8:0]  fetch_pc;
  logic        mode_wrap;
  logic        rd_ready;

  logic        rd_valid, rd_we, done, timeout;
  logic [8:0]  rd_pc;
  logic [4:0]  rd_rd;
  logic [31:0] rd_data, rd_stamp;
  logic [2:0]  count;
  logic [15:0] drops;
  logic [1:0]  state;

  logic        a_rd_valid, a_rd_we, a_done, a_timeout;
  logic [8:0]  a_rd_pc;
  logic [4:0]  a_rd_rd;
  logic [31:0] a_rd_data, a_rd_stamp;
  logic [2:0]  a_count;
  logic [15:0] a_drops;
  logic [1:0]  a_state;

  commit_trace_buffer #(.COMMIT_W(2), .DEPTH(4), .PC_W(9), .DATA_W(32),
                        .TIMEOUT(10000), .POST_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_we(commit_we), .commit_rd(commit_rd), .commit_data(commit_data),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .mode_wrap(mode_wrap),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_we(rd_we),
    .rd_rd(rd_rd), .rd_data(rd_data), .rd_stamp(rd_stamp), .count(count),
    .drops(drops), .state(state), .done(done), .timeout(timeout));

  commit_trace_buffer #(.COMMIT_W(2), .DEPTH(4), .PC_W(9), .DATA_W(32),
                        .TIMEOUT(20), .POST_CYCLES(3)) dut_a (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_we(commit_we), .commit_rd(commit_rd), .commit_data(commit_data),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .mode_wrap(mode_wrap),
    .rd_ready(rd_ready), .rd_valid(a_rd_valid), .rd_pc(a_rd_pc), .rd_we(a_rd_we),
    .rd_rd(a_rd_rd), .rd_data(a_rd_data), .rd_stamp(a_rd_stamp), .count(a_count),
    .drops(a_drops), .state(a_state), .done(a_done), .timeout(a_timeout));

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   m_drops;
  int   cyc;
  logic m_rec;
  ent_t sb[$];

  // Cycles since the reset edge; equals the stamp captured at the next edge.
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  function automatic ent_t mk(input logic [8:0] pc, input int st);
    ent_t e;
    e.pc    = pc;
    e.we    = pc[2];
    e.rd    = pc[6:2];
    e.data  = {pc, ~pc, pc, 5'b10101};
    e.stamp = st;
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b0; commit_valid = '0; commit_pc = '0; commit_we = '0;
    commit_rd = '0; commit_data = '0; fetch_valid = 1'b0; fetch_pc = '0;
    mode_wrap = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    m_drops = 0;
    m_rec = 1'b1;
  endtask

  // One cycle of commits (and optional pop); the model mirrors the effect.
  task automatic drive(input logic [1:0] v, input logic [8:0] p0,
                       input logic [8:0] p1, input logic pop);
    ent_t e0, e1, e;
    e0 = mk(p0, cyc);
    e1 = mk(p1, cyc);
    commit_valid = v;
    commit_pc    = {p1, p0};
    commit_we    = {e1.we, e0.we};
    commit_rd    = {e1.rd, e0.rd};
    commit_data  = {e1.data, e0.data};
    rd_ready     = pop;
    if (pop) begin
      total_cnt++;
      if (sb.size() == 0 || rd_valid !== 1'b1 || rd_pc !== sb[0].pc)
        $display("FAIL pop_head: got valid=%b pc=%h, want pc=%h (model size %0d)",
                 rd_valid, rd_pc, sb[0].pc, sb.size());
      else pass_cnt++;
      if (sb.size() > 0) void'(sb.pop_front());
    end
    if (m_rec) begin
      for (int i = 0; i < 2; i++) begin
        if (v[i]) begin
          e = (i == 0) ? e0 : e1;
          if (sb.size() < 4) sb.push_back(e);
          else if (mode_wrap) begin
            void'(sb.pop_front());
            sb.push_back(e);
            m_drops++;
          end else m_drops++;
        end
      end
    end
    @(negedge clk);
    commit_valid = '0;
    rd_ready = 1'b0;
  endtask

  task automatic pop_and_compare(input string tag);
    int n;
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      total_cnt++;
      if (rd_valid !== 1'b1 || rd_pc !== sb[0].pc || rd_we !== sb[0].we ||
          rd_rd !== sb[0].rd || rd_data !== sb[0].data || rd_stamp !== sb[0].stamp)
        $display("FAIL %s_entry%0d: got v=%b pc=%h we=%b rd=%0d data=%h stamp=%0d, want pc=%h we=%b rd=%0d data=%h stamp=%0d",
                 tag, k, rd_valid, rd_pc, rd_we, rd_rd, rd_data, rd_stamp,
                 sb[0].pc, sb[0].we, sb[0].rd, sb[0].data, sb[0].stamp);
      else pass_cnt++;
      rd_ready = 1'b1;
      void'(sb.pop_front());
      @(negedge clk);
    end
    rd_ready = 1'b0;
    total_cnt++;
    if (rd_valid !== 1'b0 || count !== 3'd0)
      $display("FAIL %s_empty: got rd_valid=%b count=%0d, want 0 0", tag, rd_valid, count);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({rd_valid, count, drops} !== 20'd0)
      $display("FAIL reset_buf: got rd_valid=%b count=%0d drops=%0d, want 0", rd_valid, count, drops);
    else pass_cnt++;
    total_cnt++;
    if ({state, done, timeout} !== 4'd0)
      $display("FAIL reset_fsm: got state=%0d done=%b timeout=%b, want 0", state, done, timeout);
    else pass_cnt++;
    total_cnt++;
    if ({a_state, a_done, a_rd_valid} !== 4'd0)
      $display("FAIL reset_a: got state=%0d done=%b rd_valid=%b, want 0", a_state, a_done, a_rd_valid);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 5; i++) drive(2'b01, 9'(i * 4), 9'h0, 1'b0);
    total_cnt++;
    if (count !== 3'd4 || drops !== 16'(m_drops) || drops !== 16'd1)
      $display("FAIL fill_count: got count=%0d drops=%0d, want 4 1", count, drops);
    else pass_cnt++;
    pop_and_compare("fill");
  endtask

  task automatic test_compaction();
    do_reset();
    drive(2'b10, 9'h000, 9'h020, 1'b0);
    drive(2'b11, 9'h024, 9'h028, 1'b0);
    total_cnt++;
    if (count !== 3'd3 || drops !== 16'd0)
      $display("FAIL compact_count: got count=%0d drops=%0d, want 3 0", count, drops);
    else pass_cnt++;
    pop_and_compare("compact");
  endtask

  task automatic test_overwrite();
    do_reset();
    mode_wrap = 1'b1;
    for (int i = 0; i < 6; i++) drive(2'b01, 9'(9'h100 + i * 4), 9'h0, 1'b0);
    total_cnt++;
    if (count !== 3'd4 || drops !== 16'(m_drops) || rd_pc !== 9'h108)
      $display("FAIL overwrite: got count=%0d drops=%0d head=%h, want 4 %0d 108", count, drops, rd_pc, m_drops);
    else pass_cnt++;
    pop_and_compare("overwrite");
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 4; i++) drive(2'b01, 9'(9'h040 + i * 4), 9'h0, 1'b0);
    drive(2'b11, 9'h050, 9'h054, 1'b1);
    total_cnt++;
    if (count !== 3'd4 || drops !== 16'(m_drops) || drops !== 16'd1)
      $display("FAIL full_pop: got count=%0d drops=%0d, want 4 1", count, drops);
    else pass_cnt++;
    pop_and_compare("full_pop");
  endtask

  task automatic test_end_detect();
    do_reset();
    fetch_valid = 1'b1;
    for (int pc = 0; pc <= 'h1FC; pc += 4) begin
      fetch_pc = 9'(pc);
      @(negedge clk);
      if (pc == 4) begin
        total_cnt++;
        if (state !== 2'd1) $display("FAIL end_run: got state=%0d, want 1", state);
        else pass_cnt++;
      end
    end
    fetch_pc = 9'h000;
    @(negedge clk);
    fetch_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (state !== 2'd2 || done !== 1'b0)
        $display("FAIL end_post%0d: got state=%0d done=%b, want 2 0", k, state, done);
      else pass_cnt++;
      if (k < 2) @(negedge clk);
    end
    drive(2'b01, 9'h0A0, 9'h0, 1'b0);
    total_cnt++;
    if (state !== 2'd3 || done !== 1'b1)
      $display("FAIL end_done: got state=%0d done=%b, want 3 1", state, done);
    else pass_cnt++;
    m_rec = 1'b0;
    drive(2'b01, 9'h0A4, 9'h0, 1'b0);
    total_cnt++;
    if (count !== 3'd1 || drops !== 16'd0 || timeout !== 1'b0)
      $display("FAIL end_after: got count=%0d drops=%0d timeout=%b, want 1 0 0", count, drops, timeout);
    else pass_cnt++;
    pop_and_compare("end");
  endtask

  task automatic test_timeout();
    do_reset();
    fetch_valid = 1'b1;
    fetch_pc = 9'h000;
    repeat (19) @(negedge clk);
    total_cnt++;
    if (a_done !== 1'b0) $display("FAIL timeout_early: got done=%b at cycle 19, want 0", a_done);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (a_done !== 1'b1 || a_timeout !== 1'b1 || a_state !== 2'd3)
      $display("FAIL timeout_fire: got done=%b timeout=%b state=%0d, want 1 1 3", a_done, a_timeout, a_state);
    else pass_cnt++;
    total_cnt++;
    if (done !== 1'b0 || state !== 2'd0)
      $display("FAIL timeout_long: got done=%b state=%0d, want 0 0", done, state);
    else pass_cnt++;
    fetch_valid = 1'b0;
  endtask

  task automatic test_reset_in_post();
    do_reset();
    fetch_valid = 1'b1;
    fetch_pc = 9'h004;
    drive(2'b11, 9'h030, 9'h034, 1'b0);
    fetch_pc = 9'h000;
    drive(2'b01, 9'h038, 9'h0, 1'b0);
    total_cnt++;
    if (state !== 2'd2 || count !== 3'd3)
      $display("FAIL post_entry: got state=%0d count=%0d, want 2 3", state, count);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (state !== 2'd0 || count !== 3'd0 || rd_valid !== 1'b0)
      $display("FAIL post_reset: got state=%0d count=%0d rd_valid=%b, want 0 0 0", state, count, rd_valid);
    else pass_cnt++;
    rst = 1'b1;
    fetch_valid = 1'b0;
    sb.delete();
  endtask

  initial begin
    rst = 1'b0;
    commit_valid = '0; commit_pc = '0; commit_we = '0; commit_rd = '0;
    commit_data = '0; fetch_valid = 1'b0; fetch_pc = '0; mode_wrap = 1'b0;
    rd_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_compaction();
    test_overwrite();
    test_full_pop();
    test_end_detect();
    test_timeout();
    test_reset_in_post();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
